// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - timed highway/country-road phase scheduler
// Optional emergency preemption under `TRAFFIC_EMERG_PREEMPT_EN.
module traffic_phase_scheduler #(
  parameter int CNT_W           = 8,
  parameter int MIN_HWY_GREEN   = 8,
  parameter int YELLOW_TIME     = 3,
  parameter int CLEAR_TIME      = 2,
  parameter int MIN_CNTRY_GREEN = 4,
  parameter int MAX_CNTRY_GREEN = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
`ifdef TRAFFIC_EMERG_PREEMPT_EN
  input  logic             emerg_req,
  output logic             preempt_active,
`endif
  output logic [1:0]       hwy_signal,
  output logic [1:0]       cntry_road_signal,
  output logic [2:0]       state_out,
  output logic [2:0]       next_state_out,
  output logic [CNT_W-1:0] dwell_cnt,
  output logic             phase_done
);

  typedef enum logic [2:0] {
    S_HWY_GREEN    = 3'd0,
    S_HWY_YELLOW   = 3'd1,
    S_ALL_RED_A    = 3'd2,
    S_CNTRY_GREEN  = 3'd3,
    S_CNTRY_YELLOW = 3'd4,
    S_ALL_RED_B    = 3'd5
  } state_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  // Exit thresholds: a phase of N cycles leaves on the edge where dwell_cnt == N-1.
  localparam logic [CNT_W-1:0] HG_LAST   = CNT_W'(MIN_HWY_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLEAR_TIME - 1);
  localparam logic [CNT_W-1:0] CG_MIN_LAST = CNT_W'(MIN_CNTRY_GREEN - 1);
  localparam logic [CNT_W-1:0] CG_MAX_LAST = CNT_W'(MAX_CNTRY_GREEN - 1);

  if (CNT_W <= 0 || MIN_HWY_GREEN <= 0 || YELLOW_TIME <= 0 || CLEAR_TIME <= 0 ||
      MIN_CNTRY_GREEN <= 0 || MAX_CNTRY_GREEN <= 0) begin : g_bad_zero
    $error("traffic_phase_scheduler: zero or negative parameter");
  end
  if (MAX_CNTRY_GREEN < MIN_CNTRY_GREEN) begin : g_bad_order
    $error("traffic_phase_scheduler: MAX_CNTRY_GREEN < MIN_CNTRY_GREEN");
  end
  if (MIN_HWY_GREEN > (1 << CNT_W) || YELLOW_TIME > (1 << CNT_W) ||
      CLEAR_TIME > (1 << CNT_W) || MAX_CNTRY_GREEN > (1 << CNT_W)) begin : g_bad_width
    $error("traffic_phase_scheduler: time parameter does not fit CNT_W");
  end

  state_t state;
  state_t next_state;
  logic   x_meta;
  logic   x_s;
  logic   preempt;

`ifdef TRAFFIC_EMERG_PREEMPT_EN
  logic er_meta;
  logic er_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      er_meta        <= 1'b0;
      er_s           <= 1'b0;
      preempt_active <= 1'b0;
    end else begin
      er_meta        <= emerg_req;
      er_s           <= er_meta;
      preempt_active <= er_s;
    end
  end

  assign preempt = er_s;
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_meta <= 1'b0;
      x_s    <= 1'b0;
    end else begin
      x_meta <= x;
      x_s    <= x_meta;
    end
  end

  always_comb begin
    next_state = S_HWY_GREEN;
    case (state)
      S_HWY_GREEN:
        next_state = (dwell_cnt >= HG_LAST && x_s && !preempt) ? S_HWY_YELLOW : S_HWY_GREEN;
      S_HWY_YELLOW:
        next_state = (dwell_cnt == Y_LAST) ? S_ALL_RED_A : S_HWY_YELLOW;
      S_ALL_RED_A:
        next_state = (dwell_cnt == CLR_LAST) ? S_CNTRY_GREEN : S_ALL_RED_A;
      S_CNTRY_GREEN:
        next_state = (preempt || (dwell_cnt >= CG_MIN_LAST && !x_s) || dwell_cnt == CG_MAX_LAST)
                     ? S_CNTRY_YELLOW : S_CNTRY_GREEN;
      S_CNTRY_YELLOW:
        next_state = (dwell_cnt == Y_LAST) ? S_ALL_RED_B : S_CNTRY_YELLOW;
      S_ALL_RED_B:
        next_state = (dwell_cnt == CLR_LAST) ? S_HWY_GREEN : S_ALL_RED_B;
      default:
        next_state = S_HWY_GREEN;
    endcase
  end

  // Heads are decoded from the next state so they flip on the same edge as state_out.
  function automatic logic [3:0] heads(input state_t s);
    case (s)
      S_HWY_GREEN:    heads = {GREEN, RED};
      S_HWY_YELLOW:   heads = {YELLOW, RED};
      S_CNTRY_GREEN:  heads = {RED, GREEN};
      S_CNTRY_YELLOW: heads = {RED, YELLOW};
      default:        heads = {RED, RED};
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_HWY_GREEN;
      dwell_cnt         <= '0;
      phase_done        <= 1'b0;
      hwy_signal        <= GREEN;
      cntry_road_signal <= RED;
    end else begin
      state      <= next_state;
      phase_done <= (next_state != state);
      {hwy_signal, cntry_road_signal} <= heads(next_state);
      if (next_state != state) begin
        dwell_cnt <= '0;
      end else if (dwell_cnt != '1) begin
        dwell_cnt <= dwell_cnt + CNT_W'(1);
      end
    end
  end

  assign state_out      = state;
  assign next_state_out = next_state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - scoreboard bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

  logic       clk;
  logic       reset;
  logic       x;
  logic [1:0] hwy_signal;
  logic [1:0] cntry_road_signal;
  logic [2:0] state_out;
  logic [2:0] next_state_out;
  logic [7:0] dwell_cnt;
  logic       phase_done;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
  logic       emerg_req;
  logic       preempt_active;
`endif

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  typedef struct {
    int         at_edge;
    logic [2:0] st;
  } ev_t;
  ev_t exp_q[$];

  traffic_phase_scheduler dut (
    .clk               (clk),
    .reset             (reset),
    .x                 (x),
`ifdef TRAFFIC_EMERG_PREEMPT_EN
    .emerg_req         (emerg_req),
    .preempt_active    (preempt_active),
`endif
    .hwy_signal        (hwy_signal),
    .cntry_road_signal (cntry_road_signal),
    .state_out         (state_out),
    .next_state_out    (next_state_out),
    .dwell_cnt         (dwell_cnt),
    .phase_done        (phase_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety invariant: never two non-RED heads at once.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      assert (!(hwy_signal != 2'd0 && cntry_road_signal != 2'd0))
      else begin
        errors++;
        $display("FAIL safety hwy=%0d cntry=%0d", hwy_signal, cntry_road_signal);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic push_ev(input int e, input logic [2:0] s);
    ev_t ev;
    ev.at_edge = e;
    ev.st      = s;
    exp_q.push_back(ev);
  endtask

  task automatic apply_reset(input logic xv);
    @(negedge clk);
    reset = 1'b0;
    x     = xv;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
    emerg_req = 1'b0;
`endif
    repeat (2) @(negedge clk);
    exp_q.delete();
    edge_no = 0;
    reset   = 1'b1;
  endtask

  // Advances to edge `upto`, scoring every phase_done pulse against the queue.
  task automatic run_edges(input int upto);
    ev_t        ev;
    logic [1:0] h_exp;
    logic [1:0] c_exp;
    while (edge_no < upto) begin
      @(posedge clk);
      edge_no++;
      @(negedge clk);
      h_exp = (state_out == 3'd0) ? 2'd2 : (state_out == 3'd1) ? 2'd1 : 2'd0;
      c_exp = (state_out == 3'd3) ? 2'd2 : (state_out == 3'd4) ? 2'd1 : 2'd0;
      checks++;
      if ({hwy_signal, cntry_road_signal} !== {h_exp, c_exp}) begin
        errors++;
        $display("FAIL heads edge=%0d state=%0d got=%0d/%0d exp=%0d/%0d",
                 edge_no, state_out, hwy_signal, cntry_road_signal, h_exp, c_exp);
      end
      if (phase_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_phase edge=%0d state=%0d", edge_no, state_out);
        end else begin
          ev = exp_q.pop_front();
          if (ev.at_edge !== edge_no || ev.st !== state_out || dwell_cnt !== 8'd0) begin
            errors++;
            $display("FAIL transition got edge=%0d state=%0d dwell=%0d exp edge=%0d state=%0d dwell=0",
                     edge_no, state_out, dwell_cnt, ev.at_edge, ev.st);
          end
        end
      end
      if (exp_q.size() > 0 && exp_q[0].at_edge < edge_no) begin
        ev = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_transition edge=%0d state=%0d exp edge=%0d state=%0d",
                 edge_no, state_out, ev.at_edge, ev.st);
      end
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftover=%0d exp=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    x     = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({state_out, hwy_signal, cntry_road_signal, dwell_cnt, phase_done} !==
        {3'd0, 2'd2, 2'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset state=%0d hwy=%0d cntry=%0d dwell=%0d pd=%0b exp 0/2/0/0/0",
               state_out, hwy_signal, cntry_road_signal, dwell_cnt, phase_done);
    end
  endtask

  task automatic test_idle_saturation();
    int e;
    apply_reset(1'b0);
    for (int k = 1; k <= 300; k++) begin
      run_edges(k);
      checks++;
      if (state_out !== 3'd0) begin
        errors++;
        $display("FAIL idle_state edge=%0d got=%0d exp=0", k, state_out);
      end
      if (k == 1 || k == 50 || k == 254 || k == 255 || k == 300) begin
        e = (k > 255) ? 255 : k;
        checks++;
        if (dwell_cnt !== 8'(e)) begin
          errors++;
          $display("FAIL idle_dwell edge=%0d got=%0d exp=%0d", k, dwell_cnt, e);
        end
      end
    end
    check_drained("idle");
  endtask

  task automatic test_max_green_back_to_back();
    apply_reset(1'b1);
    for (int c = 0; c < 2; c++) begin
      push_ev(c * 28 + 8,  3'd1);
      push_ev(c * 28 + 11, 3'd2);
      push_ev(c * 28 + 13, 3'd3);
      push_ev(c * 28 + 23, 3'd4);
      push_ev(c * 28 + 26, 3'd5);
      push_ev(c * 28 + 28, 3'd0);
    end
    run_edges(60);
    check_drained("max_green");
  endtask

  task automatic test_min_green();
    apply_reset(1'b1);
    push_ev(8, 3'd1);
    push_ev(11, 3'd2);
    push_ev(13, 3'd3);
    push_ev(17, 3'd4);
    push_ev(20, 3'd5);
    push_ev(22, 3'd0);
    run_edges(13);
    x = 1'b0;
    run_edges(40);
    check_drained("min_green");
  endtask

  task automatic test_short_x_pulse();
    apply_reset(1'b0);
    run_edges(2);
    x = 1'b1;
    run_edges(3);
    x = 1'b0;
    run_edges(40);
    checks++;
    if (state_out !== 3'd0 || dwell_cnt !== 8'd40) begin
      errors++;
      $display("FAIL short_pulse state=%0d dwell=%0d exp state=0 dwell=40", state_out, dwell_cnt);
    end
    check_drained("short_pulse");
  endtask

  task automatic test_async_reset();
    apply_reset(1'b1);
    push_ev(8, 3'd1);
    push_ev(11, 3'd2);
    push_ev(13, 3'd3);
    run_edges(15);
    checks++;
    if (state_out !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_state got=%0d exp=3", state_out);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({state_out, hwy_signal, cntry_road_signal, dwell_cnt, phase_done} !==
        {3'd0, 2'd2, 2'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset state=%0d hwy=%0d cntry=%0d dwell=%0d pd=%0b exp 0/2/0/0/0",
               state_out, hwy_signal, cntry_road_signal, dwell_cnt, phase_done);
    end
    check_drained("async_reset");
    repeat (2) @(negedge clk);
  endtask

`ifdef TRAFFIC_EMERG_PREEMPT_EN
  task automatic test_preempt();
    apply_reset(1'b1);
    push_ev(8, 3'd1);
    push_ev(11, 3'd2);
    push_ev(13, 3'd3);
    push_ev(17, 3'd4);
    push_ev(20, 3'd5);
    push_ev(22, 3'd0);
    run_edges(14);
    emerg_req = 1'b1;
    run_edges(45);
    checks++;
    if (state_out !== 3'd0 || preempt_active !== 1'b1) begin
      errors++;
      $display("FAIL preempt_hold state=%0d pa=%0b exp state=0 pa=1", state_out, preempt_active);
    end
    check_drained("preempt");
    emerg_req = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b0;
    x     = 1'b0;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
    emerg_req = 1'b0;
`endif
    test_reset();
    test_idle_saturation();
    test_max_green_back_to_back();
    test_min_green();
    test_short_x_pulse();
    test_async_reset();
`ifdef TRAFFIC_EMERG_PREEMPT_EN
    test_preempt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
